// File: rtl/gold_seq_gen.sv
// Gold-sequence generator for NR scrambling: two 31-bit LFSRs advanced eight
// steps per clock, presenting the sequence one byte at a time after an Nc-bit warm-up.
module gold_seq_gen #(
  parameter int NC = 1600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [30:0] i_c_init,
  input  logic        i_get,
  output logic [7:0]  o_byte,
  output logic        o_valid,
  output logic        o_busy
);

  localparam int CNT_MAX = NC / 8 - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    FILL,
    READY
  } state_t;

  state_t           state_q, state_d;
  logic [30:0]      x1_q, x1_d;
  logic [30:0]      x2_q, x2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [30:0]      x1_adv;
  logic [30:0]      x2_adv;
  logic [7:0]       c_cur;

  // Bit i of each register holds x(n+i); the new bit x(n+31) enters at the top.
  function automatic logic [30:0] adv_x1(input logic [30:0] s);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[3] ^ t[0], t[30:1]};
    end
    return t;
  endfunction

  function automatic logic [30:0] adv_x2(input logic [30:0] s);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[3] ^ t[2] ^ t[1] ^ t[0], t[30:1]};
    end
    return t;
  endfunction

  assign x1_adv = adv_x1(x1_q);
  assign x2_adv = adv_x2(x2_q);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cbit
      assign c_cur[gi] = x1_q[gi] ^ x2_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
      end
      WARMUP: begin
        x1_d = x1_adv;
        x2_d = x2_adv;
        // Counter saturates at its last value so it never wraps mid warm-up.
        if (cnt_q == CNT_LAST) begin
          state_d = FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL: begin
        byte_d  = c_cur;
        x1_d    = x1_adv;
        x2_d    = x2_adv;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = READY;
      end
      READY: begin
        if (i_get) begin
          byte_d = c_cur;
          x1_d   = x1_adv;
          x2_d   = x2_adv;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start overrides everything, including a coincident get.
    if (i_start) begin
      state_d = WARMUP;
      x1_d    = 31'd1;
      x2_d    = i_c_init;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x1_q    <= '0;
      x2_q    <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_byte  = byte_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_gold_seq_gen.sv
// Self-checking bench for gold_seq_gen: vector table plus restart, collision
// and reset sequences, scored against a bit-serial Gold-sequence model.
module tb_gold_seq_gen;

  localparam int NC      = 1600;
  localparam int MAXB    = 80;
  localparam int MODEL_N = NC + 8 * MAXB + 31;
  localparam int LAT     = NC / 8 + 1;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [30:0] i_c_init;
  logic        i_get;
  logic [7:0]  o_byte;
  logic        o_valid;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] ref_bytes [0:MAXB-1];
  bit         mx1 [0:MODEL_N-1];
  bit         mx2 [0:MODEL_N-1];

  typedef struct {
    logic [30:0] c_init;
    int          n_gets;
    int          gap;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:4];

  gold_seq_gen #(.NC(NC)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_c_init (i_c_init),
    .i_get    (i_get),
    .o_byte   (o_byte),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Direct recurrence from the sequence definition, one bit per index.
  task automatic model(input logic [30:0] ci, input int nb);
    for (int n = 0; n < 31; n++) begin
      mx1[n] = (n == 0);
      mx2[n] = ci[n];
    end
    for (int n = 0; n + 31 < MODEL_N; n++) begin
      mx1[n+31] = mx1[n+3] ^ mx1[n];
      mx2[n+31] = mx2[n+3] ^ mx2[n+2] ^ mx2[n+1] ^ mx2[n];
    end
    for (int m = 0; m < nb; m++) begin
      for (int k = 0; k < 8; k++) begin
        ref_bytes[m][k] = mx1[NC + 8*m + k] ^ mx2[NC + 8*m + k];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [30:0] ci, input logic with_get);
    i_start  = 1'b1;
    i_c_init = ci;
    i_get    = with_get;
    tick();
    i_start = 1'b0;
    i_get   = 1'b0;
    chk("start_valid_low", {31'd0, o_valid}, 32'd0);
    chk("start_busy_high", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    int busy_cyc;
    lat      = 0;
    busy_cyc = 0;
    while (!o_valid && lat < 400) begin
      tick();
      lat++;
      if (!o_valid && o_busy) busy_cyc++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_cyc), 32'(NC / 8));
    chk("busy_after_fill", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_byte0();
    logic [7:0] e;
    exp_q.push_back(ref_bytes[0]);
    e = exp_q.pop_front();
    chk("byte0", {24'd0, o_byte}, {24'd0, e});
    $display("byte m=0 got=%02h exp=%02h", o_byte, e);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] e;
    logic [7:0] last;
    model(v.c_init, v.n_gets + 1);
    do_start(v.c_init, 1'b0);
    wait_valid(v.exp_lat);
    check_byte0();
    last = o_byte;
    for (int g = 0; g < v.n_gets; g++) begin
      i_get = 1'b1;
      exp_q.push_back(ref_bytes[g+1]);
      tick();
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream_byte", {24'd0, o_byte}, {24'd0, e});
        $display("byte m=%0d got=%02h exp=%02h", g + 1, o_byte, e);
      end
      chk("stream_valid", {31'd0, o_valid}, 32'd1);
      last = o_byte;
      if (v.gap > 1) begin
        i_get = 1'b0;
        for (int w = 1; w < v.gap; w++) begin
          tick();
          chk("hold_byte", {24'd0, o_byte}, {24'd0, last});
        end
      end
    end
    i_get = 1'b0;
  endtask

  initial begin
    int valid_seen;

    vecs[0] = '{c_init: 31'h0000000, n_gets: 4,  gap: 1, exp_lat: LAT};
    vecs[1] = '{c_init: 31'h1234567, n_gets: 64, gap: 1, exp_lat: LAT};
    vecs[2] = '{c_init: 31'h5A5A5A5, n_gets: 8,  gap: 8, exp_lat: LAT};
    vecs[3] = '{c_init: 31'h7FFFFFFF, n_gets: 6, gap: 3, exp_lat: LAT};
    vecs[4] = '{c_init: 31'h00003E8, n_gets: 5,  gap: 2, exp_lat: LAT};

    rst      = 1'b1;
    i_start  = 1'b0;
    i_c_init = '0;
    i_get    = 1'b0;
    #3;
    chk("reset_byte", {24'd0, o_byte}, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Gets while idle must be ignored.
    i_get = 1'b1;
    repeat (5) tick();
    i_get = 1'b0;
    chk("idle_get_valid", {31'd0, o_valid}, 32'd0);
    chk("idle_get_busy", {31'd0, o_busy}, 32'd0);

    foreach (vecs[i]) begin
      $display("vector %0d c_init=%08h gets=%0d gap=%0d", i, vecs[i].c_init, vecs[i].n_gets, vecs[i].gap);
      run_vec(vecs[i]);
    end

    // Restart in READY, then again at warm-up cycle 100 with another seed.
    model(31'h2468ACE, 1);
    do_start(31'h1111111, 1'b0);
    repeat (100) tick();
    do_start(31'h2468ACE, 1'b0);
    wait_valid(LAT);
    check_byte0();

    // Get held high through warm-up: byte 0 must not be skipped.
    model(31'h0ABCDEF, 2);
    do_start(31'h0ABCDEF, 1'b0);
    i_get = 1'b1;
    wait_valid(LAT);
    check_byte0();
    exp_q.push_back(ref_bytes[1]);
    tick();
    i_get = 1'b0;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("warmup_get_byte1", {24'd0, o_byte}, {24'd0, e});
      $display("byte m=1 got=%02h exp=%02h", o_byte, e);
    end

    // Start and get on the same edge: the restart wins, the get is dropped.
    model(31'h3C3C3C3, 1);
    do_start(31'h3C3C3C3, 1'b1);
    wait_valid(LAT);
    check_byte0();

    // Asynchronous reset mid warm-up, then no valid without a new start.
    do_start(31'h0F0F0F0, 1'b0);
    repeat (50) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_byte", {24'd0, o_byte}, 32'd0);
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
    tick();
    rst   = 1'b0;
    i_get = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (o_valid || o_busy) valid_seen++;
    end
    i_get = 1'b0;
    chk("no_valid_after_rst", 32'(valid_seen), 32'd0);

    // Recovery after reset.
    model(31'h0F0F0F0, 1);
    do_start(31'h0F0F0F0, 1'b0);
    wait_valid(LAT);
    check_byte0();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gold_seq_gen.md
GOLD_SEQ_GEN -- requirements
Module: gold_seq_gen

Interface
REQ-001 SHALL have parameter NC, default 1600: Gold-sequence offset Nc per TS 38.211 5.2.1; legal values are multiples of 8 that are at least 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_start, input, 1 bit: one-cycle pulse; loads i_c_init and restarts the sequence.
REQ-005 SHALL have port i_c_init, input, 31 bits: c_init, sampled only on the i_start edge.
REQ-006 SHALL have port i_get, input, 1 bit: request the next byte; honoured only while o_valid=1.
REQ-007 SHALL have port o_byte, output, 8 bits: current sequence byte; o_byte[k] = c(8m+k) for byte index m.
REQ-008 SHALL have port o_valid, output, 1 bit: o_byte holds a legal sequence byte.
REQ-009 SHALL have port o_busy, output, 1 bit: warm-up in progress.

Function
REQ-010 SHALL implement x1(n+31) = x1(n+3) ^ x1(n), x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n), and c(n) = x1(n+NC) ^ x2(n+NC).
REQ-011 SHALL, on the edge where i_start=1 (edge S), load x1 = 31'd1 and x2 = i_c_init, clear o_valid, set o_busy=1, and clear the warm-up counter.
REQ-012 SHALL advance both LFSRs by 8 steps per clock, computed combinationally as 8 unrolled steps; no multi-cycle paths.
REQ-013 SHALL use a state machine with states IDLE, WARMUP, FILL, READY.
- IDLE: waits for i_start.
- WARMUP: lasts NC/8 cycles, edges S+1 .. S+NC/8.
- FILL: one cycle.
- READY: holds the output byte.
REQ-014 SHALL, in FILL (edge S+NC/8+1), load o_byte with c(0..7), advance the LFSRs 8 steps, set o_valid=1, set o_busy=0, and enter READY; with NC=1600, o_valid first rises after edge S+201.
REQ-015 SHALL, in READY on an edge with i_get=1, load o_byte with the next 8 bits c(8m+8..8m+15), advance the LFSRs 8 steps, and keep o_valid=1; the next byte is therefore visible in the cycle after the get.
REQ-016 SHALL hold o_byte and the LFSR state unchanged in READY while i_get=0; back-to-back i_get on every cycle SHALL produce consecutive bytes with no gaps.
REQ-017 SHALL ignore i_get in IDLE, WARMUP and FILL: no state change and no error.
REQ-018 SHALL give i_start priority over i_get when both are high on the same edge: the restart per REQ-011 applies and the get is discarded.
REQ-019 SHALL accept i_start in any state, including mid-WARMUP; the warm-up restarts from zero with the new c_init.
REQ-020 SHALL wrap the byte sequence without limit; the block has no length count, so the consumer stops requesting.
REQ-021 SHALL size the warm-up counter to hold NC/8-1, and SHALL NOT let it wrap during WARMUP.

Reset
REQ-022 SHALL, while rst=1, asynchronously force state=IDLE, o_byte=0, o_valid=0, o_busy=0, x1=0, x2=0 and warm-up counter=0.
REQ-023 SHALL, if rst asserts mid-WARMUP or in READY, discard all progress; after release the block stays in IDLE until the next i_start.

Verification
REQ-024 Start latency: i_start with c_init=31'h0 -> o_busy=1 for 200 cycles, o_valid rises exactly 201 edges after the start edge, and o_byte equals the golden-model byte 0 for c_init=0.
REQ-025 Streaming: c_init=31'h1234567 with i_get held high for 64 cycles -> 64 consecutive bytes match a bit-serial TS 38.211 reference model, no repeats and no skips.
REQ-026 Sparse get: i_get pulsed every 8th cycle (the scrambler pattern) -> o_byte is stable between gets, each new byte appears one cycle after its get, and all bytes match the model.
REQ-027 Restart: i_start at warm-up cycle 100, then i_start with a new c_init while in READY -> o_valid=0 the next cycle, and the first byte after 201 edges matches the model for the new c_init.
REQ-028 Collisions and reset: i_start and i_get in the same cycle -> restart only; rst asserted mid-WARMUP -> all outputs 0 immediately, and no o_valid rises without a new i_start.
